demux_router_1to4: RTL and testbench
====================================

DEMUX_ROUTER_1TO4 -- requirements
Module: demux_router_1to4

Interface
REQ-001 Parameter: width, default 8, data bits per word.
REQ-002 Parameter: depth, default 2, entries per output channel buffer (power of two, ≥2).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i  input  width  input data word.
REQ-006 sel  input  2  destination channel (0..3) for i.
REQ-007 i_valid  input  1  i/sel valid this cycle.
REQ-008 i_ready  output  1  router accepts i/sel this cycle.
REQ-009 o0..o3  output  width each  head word of channel n buffer.
REQ-010 o0_valid..o3_valid  output  1 each  channel n head word valid.
REQ-011 o0_ready..o3_ready  input  1 each  consumer n takes head word.

Function
REQ-012 Input transfer occurs when i_valid && i_ready on a rising edge; word i is written into the channel buffer indexed by sel.
REQ-013 i_ready SHALL equal NOT full of the buffer selected by the current sel (combinational on sel); it is independent of i_valid.
REQ-014 Output transfer on channel n occurs when on_valid && on_ready; the head word is removed on that edge.
REQ-015 on_valid SHALL be 1 iff channel n count > 0; on SHALL show the oldest stored word, 0 when empty.
REQ-016 Latency: a word accepted at edge k SHALL appear on its on/on_valid after edge k (one cycle) if the channel was empty.
REQ-017 Each channel SHALL be FIFO order; words never reorder within a channel and never appear on a non-selected channel.
REQ-018 Per-channel count range 0..depth; read/write pointers wrap modulo depth.
REQ-019 Simultaneous push and pop on one channel that is non-empty and non-full: count unchanged, both transfers occur.
REQ-020 Full channel: i_ready=0 for that sel even if on_ready=1 in the same cycle (no pass-through); other channels remain accepting.
REQ-021 Empty channel with push and on_ready same cycle: only the push occurs; no bypass.
REQ-022 on_ready while on_valid=0 SHALL have no effect.
REQ-023 Channels operate independently; pops on all four plus one push in the same cycle SHALL all complete.
REQ-024 Status counters: each channel maintains a count of clog2(depth)+1 bits; no overflow/underflow is possible under REQ-013/REQ-022.

Reset
REQ-025 On rst=1 at a rising edge: all counts and pointers 0, all on_valid=0, all on=0.
REQ-026 While rst=1, i_ready SHALL be 0 and no transfers occur.
REQ-027 Reset mid-operation discards all buffered words; first cycle after rst falls, i_ready=1 for every sel.
REQ-028 Buffer storage contents need not be reset; outputs are masked to 0 when empty.

Structure
REQ-029 Shared package demux_pkg SHALL hold NUM_CH=4, SEL_W=2 and the channel index type.
REQ-030 One sub-module, demux_chan_fifo (width, depth parameters; push, pop, data, count, full, empty), instantiated four times; top holds sel decode and ready mux.

Verification
REQ-031 Reset then i=8'hA0,sel=0,i_valid=1 one cycle -> next cycle o0=8'hA0,o0_valid=1; o1..o3_valid=0.
REQ-032 Sequence A0/sel0, B0/sel1, C0/sel2, D0/sel3, all on_ready=1 -> each appears only on its channel, one cycle after its acceptance.
REQ-033 o0_ready=0, push 8'h11,8'h22 to sel0 -> i_ready=0 for sel=0, 1 for sel=1; raising o0_ready yields 11 then 22.
REQ-034 Channel 2 holding one word, push 8'h33 to sel2 with o2_ready=1 -> count stays 1, old word popped, o2=8'h33 next cycle.
REQ-035 Two words buffered in channel 3, assert rst one cycle -> all on_valid=0, all on=0, i_ready=1 after release.
REQ-036 Random stimulus 1000 cycles vs. scoreboard of four queues -> zero order/data/route mismatches, no transfer while on_valid=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demux router.
// Channel count, select width, channel index type, select decoder.
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0] chan_idx_t;

   function automatic logic [NUM_CH-1:0] chan_onehot(
      input chan_idx_t idx
   );
      logic [NUM_CH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO buffer: depth entries of width bits.
// Ports: clk, rst, i_push, i_pop, i_data, o_data (raw head), o_count, o_full, o_empty.
module demux_chan_fifo #(
   parameter  int width = 8,
   parameter  int depth = 2,
   localparam int AW    = $clog2(depth),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [width-1:0] i_data,
   output logic [width-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [width-1:0] r_mem [depth];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(depth));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];

   // Guard locally so a full push or empty pop can never corrupt state.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // Storage carries no reset; emptiness masks stale contents.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointers wrap naturally because depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/demux_router_1to4.sv
// 1-to-4 demux router: input word steered by sel into one of four FIFOs.
// Ports: clk, rst, i/sel/i_valid/i_ready in; o0..o3 with _valid/_ready out.
module demux_router_1to4
   import demux_pkg::*;
#(
   parameter int width = 8,
   parameter int depth = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] i,
   input  logic [SEL_W-1:0] sel,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [width-1:0] o0,
   output logic [width-1:0] o1,
   output logic [width-1:0] o2,
   output logic [width-1:0] o3,
   output logic             o0_valid,
   output logic             o1_valid,
   output logic             o2_valid,
   output logic             o3_valid,
   input  logic             o0_ready,
   input  logic             o1_ready,
   input  logic             o2_ready,
   input  logic             o3_ready
);

   localparam int CW = $clog2(depth) + 1;

   logic [width-1:0]  w_data  [NUM_CH];
   logic [width-1:0]  w_out   [NUM_CH];
   logic [CW-1:0]     w_count [NUM_CH];
   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_empty;
   logic [NUM_CH-1:0] w_valid;
   logic [NUM_CH-1:0] w_ordy;
   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;

   // Ready follows sel only; a full channel never passes through.
   assign i_ready = ~rst & ~w_full[sel];

   assign w_push = (i_valid & i_ready) ? chan_onehot(sel) : '0;
   assign w_ordy = {o3_ready, o2_ready, o1_ready, o0_ready};
   assign w_pop  = w_ordy & w_valid;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      demux_chan_fifo #(
         .width (width),
         .depth (depth)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_push  (w_push[n]),
         .i_pop   (w_pop[n]),
         .i_data  (i),
         .o_data  (w_data[n]),
         .o_count (w_count[n]),
         .o_full  (w_full[n]),
         .o_empty (w_empty[n])
      );

      assign w_valid[n] = (w_count[n] != '0);
      assign w_out[n]   = w_empty[n] ? '0 : w_data[n];
   end

   assign o0 = w_out[0];
   assign o1 = w_out[1];
   assign o2 = w_out[2];
   assign o3 = w_out[3];

   assign o0_valid = w_valid[0];
   assign o1_valid = w_valid[1];
   assign o2_valid = w_valid[2];
   assign o3_valid = w_valid[3];

endmodule

// File: tb/tb_demux_router_1to4.sv
// Testbench for demux_router_1to4: directed cases plus random traffic
// checked by a four-queue scoreboard and an independent monitor.
module tb_demux_router_1to4;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] i   = '0;
   logic [1:0]       sel = '0;
   logic             i_valid = 1'b0;
   logic             i_ready;
   logic [WIDTH-1:0] o0, o1, o2, o3;
   logic             o0_valid, o1_valid, o2_valid, o3_valid;
   logic             o0_ready = 1'b0;
   logic             o1_ready = 1'b0;
   logic             o2_ready = 1'b0;
   logic             o3_ready = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   logic [WIDTH-1:0] q [4][$];

   logic [WIDTH-1:0] od [4];
   logic [3:0]       ov;
   logic [3:0]       ordy;

   assign od[0] = o0;
   assign od[1] = o1;
   assign od[2] = o2;
   assign od[3] = o3;
   assign ov    = {o3_valid, o2_valid, o1_valid, o0_valid};
   assign ordy  = {o3_ready, o2_ready, o1_ready, o0_ready};

   always #5 clk = ~clk;

   demux_router_1to4 #(
      .width (WIDTH),
      .depth (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i        (i),
      .sel      (sel),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .o0       (o0),
      .o1       (o1),
      .o2       (o2),
      .o3       (o3),
      .o0_valid (o0_valid),
      .o1_valid (o1_valid),
      .o2_valid (o2_valid),
      .o3_valid (o3_valid),
      .o0_ready (o0_ready),
      .o1_ready (o1_ready),
      .o2_ready (o2_ready),
      .o3_ready (o3_ready)
   );

   // Monitor: mid-cycle view of each channel against its queue head.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int ch = 0; ch < 4; ch++) begin
            logic exp_v;
            logic [WIDTH-1:0] exp_d;
            exp_v = (q[ch].size() > 0);
            exp_d = exp_v ? q[ch][0] : '0;
            n_chk++;
            if (ov[ch] !== exp_v) begin
               n_fail++;
               $display("FAIL valid ch%0d: got %b want %b t=%0t",
                        ch, ov[ch], exp_v, $time);
            end
            n_chk++;
            if (od[ch] !== exp_d) begin
               n_fail++;
               $display("FAIL data ch%0d: got %h want %h t=%0t",
                        ch, od[ch], exp_d, $time);
            end
            if (!rst && ordy[ch] && exp_v) begin
               void'(q[ch].pop_front());
            end
         end
      end
   end

   task automatic chk_ready(input logic exp, input string nm);
      n_chk++;
      if (i_ready !== exp) begin
         n_fail++;
         $display("FAIL %s: i_ready got %b want %b sel=%0d t=%0t",
                  nm, i_ready, exp, sel, $time);
      end
   endtask

   // One clock cycle of stimulus; scoreboard push happens after the monitor.
   task automatic cyc(input logic r, input logic v, input logic [1:0] s,
                      input logic [WIDTH-1:0] d, input logic [3:0] rdy);
      logic exp_rdy;
      @(posedge clk);
      #1;
      rst      = r;
      i_valid  = v;
      sel      = s;
      i        = d;
      o0_ready = rdy[0];
      o1_ready = rdy[1];
      o2_ready = rdy[2];
      o3_ready = rdy[3];
      #1;
      if (mon_en) begin
         exp_rdy = !r && (q[s].size() < DEPTH);
         chk_ready(exp_rdy, "ready");
      end
      @(negedge clk);
      #1;
      if (r) begin
         for (int ch = 0; ch < 4; ch++) q[ch].delete();
      end else if (v && exp_rdy && mon_en) begin
         q[s].push_back(d);
      end
   endtask

   task automatic idle(input int n, input logic [3:0] rdy);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 2'd0, '0, rdy);
   endtask

   initial begin
      cyc(1'b1, 1'b0, 2'd0, '0, 4'b0000);
      mon_en = 1'b1;
      cyc(1'b1, 1'b0, 2'd0, '0, 4'b0000);

      // Single word to channel 0, then visible next cycle.
      cyc(1'b0, 1'b1, 2'd0, 8'hA0, 4'b0000);
      idle(1, 4'b0000);
      idle(2, 4'b1111);

      // One word per channel with all consumers ready.
      cyc(1'b0, 1'b1, 2'd0, 8'hA0, 4'b1111);
      cyc(1'b0, 1'b1, 2'd1, 8'hB0, 4'b1111);
      cyc(1'b0, 1'b1, 2'd2, 8'hC0, 4'b1111);
      cyc(1'b0, 1'b1, 2'd3, 8'hD0, 4'b1111);
      idle(2, 4'b1111);

      // Fill channel 0; full blocks sel0 even with o0_ready, sel1 open.
      cyc(1'b0, 1'b1, 2'd0, 8'h11, 4'b0000);
      cyc(1'b0, 1'b1, 2'd0, 8'h22, 4'b0000);
      cyc(1'b0, 1'b1, 2'd0, 8'h55, 4'b0001);
      cyc(1'b0, 1'b1, 2'd1, 8'h66, 4'b0010);
      idle(3, 4'b0001);
      idle(1, 4'b1111);

      // Simultaneous push and pop on a one-deep channel 2.
      cyc(1'b0, 1'b1, 2'd2, 8'h77, 4'b0000);
      cyc(1'b0, 1'b1, 2'd2, 8'h33, 4'b0100);
      idle(1, 4'b0000);
      idle(2, 4'b1111);

      // Empty-channel push with ready: no bypass.
      cyc(1'b0, 1'b1, 2'd1, 8'h44, 4'b0010);
      idle(2, 4'b1111);

      // All four pops plus one push in one cycle.
      cyc(1'b0, 1'b1, 2'd0, 8'h01, 4'b0000);
      cyc(1'b0, 1'b1, 2'd1, 8'h02, 4'b0000);
      cyc(1'b0, 1'b1, 2'd2, 8'h03, 4'b0000);
      cyc(1'b0, 1'b1, 2'd3, 8'h04, 4'b0000);
      cyc(1'b0, 1'b1, 2'd2, 8'h05, 4'b1111);
      idle(3, 4'b1111);

      // Reset with channel 3 holding two words.
      cyc(1'b0, 1'b1, 2'd3, 8'hE1, 4'b0000);
      cyc(1'b0, 1'b1, 2'd3, 8'hE2, 4'b0000);
      cyc(1'b1, 1'b1, 2'd3, 8'hE3, 4'b1111);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      i_valid  = 1'b0;
      o0_ready = 1'b0;
      o1_ready = 1'b0;
      o2_ready = 1'b0;
      o3_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         chk_ready(1'b1, "ready_after_rst");
      end
      idle(1, 4'b0000);

      // Random traffic with biased-low consumer readiness to reach full.
      for (int k = 0; k < 1000; k++) begin
         logic r;
         r = ($urandom_range(0, 299) == 0);
         cyc(r, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             8'($urandom), 4'($urandom & $urandom));
      end
      idle(DEPTH + 2, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
